// File: rtl/crc_rtu_engine_param.sv
// ----------------------------------------------------------------------------
// crc_rtu_engine_param
//
// Parametrised bit-serial CRC engine for the serial link (TX and RX paths).
// A frame is accumulated word-by-word starting from INIT until cleared.
// Defaults implement CRC-16/MODBUS (reflected poly 0xA001, init 0xFFFF).
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   clear    in   synchronous frame restart (highest priority)
//   start    in   request strobe, only a rising edge is a request
//   byte_in  in   DATA_W data word, sampled on the accepted start edge
//   crc_out  out  CRC register XOR XOROUT, updated at job end or clear
//   busy     out  high while shifting
//   done     out  one-cycle pulse when crc_out updates after a job
//   crc_zero out  internal CRC register (pre-XOROUT) equals zero
//   overrun  out  sticky, set by a start edge seen while busy
// ----------------------------------------------------------------------------
module crc_rtu_engine_param #(
    parameter int unsigned      CRC_W          = 16,
    parameter logic [CRC_W-1:0] POLY           = 16'hA001,
    parameter logic [CRC_W-1:0] INIT           = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOROUT         = 16'h0000,
    parameter int unsigned      DATA_W         = 8,
    parameter int unsigned      BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] byte_in,
    output logic [CRC_W-1:0]  crc_out,
    output logic              busy,
    output logic              done,
    output logic              crc_zero,
    output logic              overrun
);

    localparam int unsigned      STEPS    = DATA_W / BITS_PER_CYCLE;
    localparam int unsigned      CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Advance the reflected CRC by BITS_PER_CYCLE LSB-first steps.
    function automatic logic [CRC_W-1:0] crc_advance(input logic [CRC_W-1:0] crc_in);
        logic [CRC_W-1:0] c;
        c = crc_in;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t           state_q;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             prev_start_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;

    logic             start_edge_s;
    logic [CRC_W-1:0] crc_shift_d;

    // Rising-edge detect and next shifted CRC value.
    always_comb begin
        start_edge_s = start & ~prev_start_q;
        crc_shift_d  = crc_advance(crc_q);
    end

    // Control FSM and datapath registers; the finishing update happens in
    // the same cycle as the last shift, so no separate FINISH state exists.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            crc_q        <= INIT;
            crc_out_q    <= INIT ^ XOROUT;
            cnt_q        <= {CNT_W{1'b0}};
            prev_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            prev_start_q <= start;
            done_q       <= 1'b0;
            if (clear) begin
                // Abort any in-flight word; a coincident start edge is dropped.
                state_q   <= ST_IDLE;
                crc_q     <= INIT;
                crc_out_q <= INIT ^ XOROUT;
                cnt_q     <= {CNT_W{1'b0}};
                busy_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_edge_s) begin
                            crc_q   <= crc_q ^ CRC_W'(byte_in);
                            cnt_q   <= {CNT_W{1'b0}};
                            busy_q  <= 1'b1;
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_SHIFT: begin
                        if (start_edge_s) begin
                            overrun_q <= 1'b1;
                        end else begin
                            overrun_q <= overrun_q;
                        end
                        crc_q <= crc_shift_d;
                        if (cnt_q == LAST_CNT) begin
                            crc_out_q <= crc_shift_d ^ XOROUT;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            cnt_q     <= {CNT_W{1'b0}};
                            state_q   <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign crc_out  = crc_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
    // Frame-validation compare works on the raw register, ahead of XOROUT.
    assign crc_zero = (crc_q == {CRC_W{1'b0}});

endmodule

// File: tb/tb_crc_rtu_engine_param.sv
module tb_crc_rtu_engine_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear1 = 1'b0, start1 = 1'b0;
    logic [7:0]  byte1 = 8'h00;
    logic [15:0] crc1;
    logic        busy1, done1, zero1, ovr1;
    logic        clear4 = 1'b0, start4 = 1'b0;
    logic [7:0]  byte4 = 8'h00;
    logic [15:0] crc4;
    logic        busy4, done4, zero4, ovr4;

    int checks   = 0;
    int failures = 0;
    int lat, bcnt, dcnt;

    logic [7:0] seq123 [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [7:0] rxgood [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    logic [7:0] rxbad  [8] = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};

    always #5 clk = ~clk;

    crc_rtu_engine_param dut1 (
        .clk(clk), .reset(rst_n), .clear(clear1), .start(start1), .byte_in(byte1),
        .crc_out(crc1), .busy(busy1), .done(done1), .crc_zero(zero1), .overrun(ovr1)
    );

    crc_rtu_engine_param #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(rst_n), .clear(clear4), .start(start4), .byte_in(byte4),
        .crc_out(crc4), .busy(busy4), .done(done4), .crc_zero(zero4), .overrun(ovr4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one start edge at a falling edge and wait (bounded) for done.
    task automatic run1(input logic [7:0] b, output int l, output int bc);
        byte1 = b; start1 = 1'b1; l = 0; bc = 0;
        do begin
            @(negedge clk); l++; start1 = 1'b0;
            if (busy1) bc++;
        end while (!done1 && l < 30);
    endtask

    task automatic run4(input logic [7:0] b, output int l);
        byte4 = b; start4 = 1'b1; l = 0;
        do begin
            @(negedge clk); l++; start4 = 1'b0;
        end while (!done4 && l < 30);
    endtask

    task automatic pulse_clear1();
        clear1 = 1'b1; @(negedge clk); clear1 = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_crc", 32'(crc1), 32'hFFFF);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_done", 32'(done1), 32'h0);
        chk("rst_ovr", 32'(ovr1), 32'h0);
        chk("rst_zero", 32'(zero1), 32'h0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);

        // Single byte 0x01
        run1(8'h01, lat, bcnt);
        chk("b01_lat", 32'(lat), 32'd9);
        chk("b01_busy_cycles", 32'(bcnt), 32'd8);
        chk("b01_crc", 32'(crc1), 32'h807E);
        @(negedge clk);
        chk("done_one_cycle", 32'(done1), 32'h0);

        // "123456789" with an idle cycle between done and next start
        pulse_clear1();
        chk("clear_crc", 32'(crc1), 32'hFFFF);
        for (int i = 0; i < 9; i++) begin
            run1(seq123[i], lat, bcnt);
            @(negedge clk);
        end
        chk("check_crc", 32'(crc1), 32'h4B37);
        chk("check_ovr", 32'(ovr1), 32'h0);

        // RX frame validation
        pulse_clear1();
        for (int i = 0; i < 6; i++) begin
            run1(rxgood[i], lat, bcnt);
            @(negedge clk);
        end
        chk("rx_frame_crc", 32'(crc1), 32'h0A84);
        chk("rx_frame_zero_pre", 32'(zero1), 32'h0);
        for (int i = 6; i < 8; i++) begin
            run1(rxgood[i], lat, bcnt);
            @(negedge clk);
        end
        chk("rx_good_zero", 32'(zero1), 32'h1);
        chk("rx_good_crc", 32'(crc1), 32'h0000);
        pulse_clear1();
        for (int i = 0; i < 8; i++) begin
            run1(rxbad[i], lat, bcnt);
            @(negedge clk);
        end
        chk("rx_bad_zero", 32'(zero1), 32'h0);

        // Start held high for 20 cycles: a single request
        pulse_clear1();
        byte1 = 8'h01; start1 = 1'b1; dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) dcnt++;
        end
        start1 = 1'b0;
        chk("held_done_count", 32'(dcnt), 32'd1);
        chk("held_crc", 32'(crc1), 32'h807E);
        chk("held_ovr", 32'(ovr1), 32'h0);

        // Second edge three cycles after the first: overrun, byte discarded
        pulse_clear1();
        byte1 = 8'h01; start1 = 1'b1; dcnt = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (done1) dcnt++;
            start1 = (i == 3) ? 1'b1 : 1'b0;
            byte1  = (i == 3) ? 8'h55 : 8'h01;
        end
        chk("ovr_done_count", 32'(dcnt), 32'd1);
        chk("ovr_crc", 32'(crc1), 32'h807E);
        chk("ovr_flag", 32'(ovr1), 32'h1);
        pulse_clear1();
        chk("ovr_cleared", 32'(ovr1), 32'h0);
        chk("ovr_clear_crc", 32'(crc1), 32'hFFFF);

        // clear mid-shift together with a start edge
        byte1 = 8'h01; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (3) @(negedge clk);
        clear1 = 1'b1; start1 = 1'b1;
        @(negedge clk); clear1 = 1'b0; start1 = 1'b0;
        chk("clr_mid_busy", 32'(busy1), 32'h0);
        chk("clr_mid_crc", 32'(crc1), 32'hFFFF);
        chk("clr_mid_ovr", 32'(ovr1), 32'h0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done1 || busy1) dcnt++;
        end
        chk("clr_mid_no_job", 32'(dcnt), 32'd0);

        // Asynchronous reset mid-shift
        run1(8'h01, lat, bcnt);
        chk("pre_rst_crc", 32'(crc1), 32'h807E);
        @(negedge clk);
        byte1 = 8'h02; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy1), 32'h0);
        chk("async_rst_crc", 32'(crc1), 32'hFFFF);
        chk("async_rst_ovr", 32'(ovr1), 32'h0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);

        // Four bits per cycle build
        run4(8'h01, lat);
        chk("bpc4_lat", 32'(lat), 32'd3);
        chk("bpc4_crc", 32'(crc4), 32'h807E);
        clear4 = 1'b1; @(negedge clk); clear4 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run4(seq123[i], lat);
            @(negedge clk);
        end
        chk("bpc4_check_crc", 32'(crc4), 32'h4B37);
        chk("bpc4_ovr", 32'(ovr4), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
